// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared opcodes, FSM encoding and byte-0 field positions for the tone sequencer
package tone_pkg;

    localparam logic [1:0] OP_SET_FREQ = 2'b00;
    localparam logic [1:0] OP_SET_VOL  = 2'b01;
    localparam logic [1:0] OP_NOTE_ON  = 2'b10;
    localparam logic [1:0] OP_NOTE_OFF = 2'b11;

    // byte 0 layout: [7:6] op, [5:4] voice, [3:0] p
    localparam int OP_HI    = 7;
    localparam int OP_LO    = 6;
    localparam int VOICE_HI = 5;
    localparam int VOICE_LO = 4;
    localparam int P_HI     = 3;
    localparam int P_LO     = 0;

    localparam int DUR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARG  = 2'd1,
        ST_EXEC = 2'd2
    } state_t;

    function automatic logic is_two_byte(input logic [1:0] op);
        return (op == OP_SET_FREQ) || (op == OP_NOTE_ON);
    endfunction

endpackage

// File: rtl/tone_duration_timer.sv
// rtl/tone_duration_timer.sv - per-voice note duration counter and gate register
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   load        NOTE_ON write: counter <= load_value, gate <= 1
//   load_value  duration in ticks (0 = sustain, no auto-off)
//   clear       NOTE_OFF write: counter <= 0, gate <= 0
//   tick        prescaler tick; decrements a nonzero counter
//   gate        1 while the voice is sounding
module tone_duration_timer
    import tone_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DUR_W-1:0] load_value,
    input  logic             clear,
    input  logic             tick,
    output logic             gate
);

    logic [DUR_W-1:0] count;

    // Command writes take priority over a coincident tick, so a reload is
    // never shortened by the tick that lands on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            gate  <= 1'b0;
        end else if (load) begin
            count <= load_value;
            gate  <= 1'b1;
        end else if (clear) begin
            count <= '0;
            gate  <= 1'b0;
        end else if (tick && (count != '0)) begin
            count <= count - DUR_W'(1);
            if (count == DUR_W'(1)) begin
                gate <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tone_cmd_sequencer.sv
// rtl/tone_cmd_sequencer.sv - byte-serial command decoder and per-voice register bank for the tone generator
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   cmd_data     command byte, accepted when cmd_valid && cmd_ready
//   cmd_valid    cmd_data valid this cycle
//   cmd_ready    low only during the single EXEC cycle (and while rst is held)
//   voice_freq   packed dividers, voice v at [v*FREQ_W +: FREQ_W]
//   voice_vol    packed volumes,  voice v at [v*VOL_W +: VOL_W]
//   voice_gate   1 = voice sounding
//   cmd_err      one-cycle pulse on a rejected or aborted command
// Build option: TONE_SEQ_TIMEOUT_EN enables the ARG-state inter-byte timeout.
module tone_cmd_sequencer
    import tone_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int FREQ_W     = 12,
    parameter int VOL_W      = 4,
    parameter int TICK_DIV   = 1000,
    parameter int TIMEOUT    = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   cmd_data,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    output logic [NUM_VOICES*FREQ_W-1:0] voice_freq,
    output logic [NUM_VOICES*VOL_W-1:0]  voice_vol,
    output logic [NUM_VOICES-1:0]        voice_gate,
    output logic                         cmd_err
);

    localparam int PW = $clog2(TICK_DIV);

    state_t     state;
    state_t     state_next;
    logic [7:0] byte0;
    logic [7:0] byte1;
    logic       accept;
    logic       timeout_hit;

    assign cmd_ready = !rst && (state != ST_EXEC);
    assign accept    = cmd_valid && cmd_ready;

    // Free-running prescaler; commands never disturb its phase.
    logic [PW-1:0] presc;
    logic          tick;

    assign tick = (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
        end
    end

`ifdef TONE_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] arg_cnt;

    // Held at zero outside ARG, so it starts from zero on every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arg_cnt <= '0;
        end else if (state != ST_ARG) begin
            arg_cnt <= '0;
        end else if (!accept && (arg_cnt != TO_W'(TIMEOUT))) begin
            arg_cnt <= arg_cnt + TO_W'(1);
        end
    end
`else
    wire unused_timeout = (TIMEOUT != 0);
`endif

    always_comb begin
        state_next  = state;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = is_two_byte(cmd_data[OP_HI:OP_LO]) ? ST_ARG : ST_EXEC;
                end
            end
            ST_ARG: begin
                if (accept) begin
                    state_next = ST_EXEC;
                end
`ifdef TONE_SEQ_TIMEOUT_EN
                else if (arg_cnt == TO_W'(TIMEOUT)) begin
                    state_next  = ST_IDLE;
                    timeout_hit = 1'b1;
                end
`endif
            end
            ST_EXEC: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            byte0 <= '0;
            byte1 <= '0;
        end else begin
            state <= state_next;
            if (accept && (state == ST_IDLE)) begin
                byte0 <= cmd_data;
            end
            if (accept && (state == ST_ARG)) begin
                byte1 <= cmd_data;
            end
        end
    end

    // Decode of the latched command, acted on at the EXEC -> IDLE edge.
    logic [1:0] op;
    logic [1:0] voice;
    logic [3:0] p;
    logic       exec;
    logic       voice_ok;
    logic       all_off;

    assign op       = byte0[OP_HI:OP_LO];
    assign voice    = byte0[VOICE_HI:VOICE_LO];
    assign p        = byte0[P_HI:P_LO];
    assign exec     = (state == ST_EXEC);
    assign voice_ok = (32'(voice) < NUM_VOICES);
    // An all-voice NOTE_OFF ignores the voice field, so it is never rejected.
    assign all_off  = (op == OP_NOTE_OFF) && p[0];
    assign cmd_err  = (exec && !voice_ok && !all_off) || timeout_hit;

    // Zero-extend then take the low bits: widens or truncates as needed.
    logic [FREQ_W+11:0] freq_wide;
    logic [VOL_W+3:0]   vol_wide;

    assign freq_wide = {{FREQ_W{1'b0}}, p, byte1};
    assign vol_wide  = {{VOL_W{1'b0}}, p};

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        logic              sel;
        logic              load;
        logic              clear;
        logic [FREQ_W-1:0] freq_q;
        logic [VOL_W-1:0]  vol_q;

        assign sel   = exec && voice_ok && (32'(voice) == v);
        assign load  = sel && (op == OP_NOTE_ON);
        assign clear = exec && (op == OP_NOTE_OFF) && (all_off || sel);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                freq_q <= '0;
                vol_q  <= '0;
            end else begin
                if (sel && (op == OP_SET_FREQ)) begin
                    freq_q <= freq_wide[FREQ_W-1:0];
                end
                if (sel && (op == OP_SET_VOL)) begin
                    vol_q <= vol_wide[VOL_W-1:0];
                end
            end
        end

        tone_duration_timer u_timer (
            .clk        (clk),
            .rst        (rst),
            .load       (load),
            .load_value (byte1),
            .clear      (clear),
            .tick       (tick),
            .gate       (voice_gate[v])
        );

        assign voice_freq[v*FREQ_W +: FREQ_W] = freq_q;
        assign voice_vol[v*VOL_W +: VOL_W]    = vol_q;
    end

endmodule

// File: tb/tb_tone_cmd_sequencer.sv
// tb/tb_tone_cmd_sequencer.sv - scoreboard bench for tone_cmd_sequencer
module tb_tone_cmd_sequencer;

    localparam int NV = 3;
    localparam int TD = 4;
    localparam int TO = 10;

    typedef struct packed {
        bit               timeout;
        bit               err;
        logic [1:0]       op;
        logic [1:0]       voice;
        logic [3:0]       p;
        logic [7:0]       b1;
        logic [NV*12-1:0] freq;
        logic [NV*4-1:0]  vol;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       cmd_data = 8'h00;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [NV*12-1:0] voice_freq;
    logic [NV*4-1:0]  voice_vol;
    logic [NV-1:0]    voice_gate;
    logic             cmd_err;

    int errors = 0;
    int checks = 0;
    int edge_cnt = 0;

    exp_t       sb[$];
    exp_t       pend;
    bit         pending = 0;
    logic [11:0] fm[4];
    logic [3:0]  vm[4];
    bit          g_on[4];
    bit          sus[4];
    int          exp_e[4];

    tone_cmd_sequencer #(
        .NUM_VOICES (NV),
        .FREQ_W     (12),
        .VOL_W      (4),
        .TICK_DIV   (TD),
        .TIMEOUT    (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .voice_freq (voice_freq),
        .voice_vol  (voice_vol),
        .voice_gate (voice_gate),
        .cmd_err    (cmd_err)
    );

    always #5 clk = ~clk;

    // Edges since reset release; tick edges are the multiples of TD.
    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NV*12-1:0] pack_freq();
        logic [NV*12-1:0] r;
        for (int v = 0; v < NV; v++) r[v*12 +: 12] = fm[v];
        return r;
    endfunction

    function automatic logic [NV*4-1:0] pack_vol();
        logic [NV*4-1:0] r;
        for (int v = 0; v < NV; v++) r[v*4 +: 4] = vm[v];
        return r;
    endfunction

    // Monitor: gate model (closed-form expiry edge) plus scoreboard pops.
    always @(negedge clk) begin
        if (rst) begin
            pending = 0;
            for (int v = 0; v < 4; v++) begin
                g_on[v] = 0;
                sus[v] = 0;
                exp_e[v] = 0;
            end
        end else begin
            int n;
            logic [NV-1:0] eg;
            n = edge_cnt;
            if (pending) begin
                if (!pend.err) begin
                    for (int v = 0; v < NV; v++) begin
                        if (pend.op == 2'b10 && pend.voice == v) begin
                            g_on[v] = 1;
                            sus[v] = (pend.b1 == 0);
                            exp_e[v] = (n / TD + 1) * TD + (int'(pend.b1) - 1) * TD;
                        end
                        if (pend.op == 2'b11 && (pend.p[0] || pend.voice == v)) g_on[v] = 0;
                    end
                end
                check("freq", voice_freq, pend.freq);
                check("vol", voice_vol, pend.vol);
                check("ready_after_exec", cmd_ready, 1);
                pending = 0;
            end
            for (int v = 0; v < NV; v++) eg[v] = g_on[v] && (sus[v] || n < exp_e[v]);
            check("gate", voice_gate, eg);
            if (!cmd_ready || cmd_err) begin
                if (sb.size() == 0) begin
                    check("unexpected_event", {cmd_ready, cmd_err}, 2'b10);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("cmd_err", cmd_err, e.err);
                    check("event_kind", cmd_ready, e.timeout);
                    if (!e.timeout) begin
                        pend = e;
                        pending = 1;
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w;
        w = 0;
        cmd_data = b;
        cmd_valid = 1;
        @(negedge clk);
        while (!cmd_ready && w < 20) begin
            w++;
            @(negedge clk);
        end
        check("ready_wait", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 0;
        cmd_data = 8'h00;
    endtask

    task automatic send_cmd(input logic [7:0] b0, input logic [7:0] b1, input int gap);
        exp_t e;
        int v;
        bit all;
        v = {30'd0, b0[5:4]};
        all = (b0[7:6] == 2'b11) && b0[0];
        e = '0;
        e.op = b0[7:6];
        e.voice = b0[5:4];
        e.p = b0[3:0];
        e.b1 = b1;
        e.err = (v >= NV) && !all;
        if (!e.err && e.op == 2'b00) fm[v] = {b0[3:0], b1};
        if (!e.err && e.op == 2'b01) vm[v] = b0[3:0];
        e.freq = pack_freq();
        e.vol = pack_vol();
        sb.push_back(e);
        send_byte(b0);
        if (e.op == 2'b00 || e.op == 2'b10) begin
            idle(gap);
            send_byte(b1);
        end
    endtask

    task automatic do_reset();
        rst = 1;
        for (int v = 0; v < 4; v++) begin
            fm[v] = 0;
            vm[v] = 0;
        end
        @(negedge clk);
        check("ready_in_reset", cmd_ready, 0);
        check("gate_in_reset", voice_gate, 0);
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        check("ready_after_rst", cmd_ready, 1);
        check("freq_after_rst", voice_freq, 0);
        check("vol_after_rst", voice_vol, 0);
        check("err_after_rst", cmd_err, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle(2);
        do_reset();

        // reset in the middle of a 2-byte command
        send_byte(8'h00);
        idle(1);
        do_reset();
        send_cmd(8'h41, 8'h00, 0);
        idle(3);

        send_cmd(8'h13, 8'h45, 0);
        idle(3);

        // timed note, sustained note, all-off
        send_cmd(8'h80, 8'h03, 0);
        idle(20);
        send_cmd(8'h80, 8'h00, 0);
        idle(100 * TD);
        send_cmd(8'hC1, 8'h00, 0);
        idle(3);

        // retrigger, then reloads at every prescaler phase
        send_cmd(8'hA0, 8'h02, 0);
        idle(TD + 1);
        send_cmd(8'hA0, 8'h05, 0);
        idle(30);
        for (int off = 0; off < TD; off++) begin
            send_cmd(8'hA0, 8'h01, off);
            idle(1);
        end
        idle(10);

        // voice 3 does not exist
        send_cmd(8'h30, 8'hAA, 0);
        send_cmd(8'h41, 8'h00, 0);
        idle(3);

`ifdef TONE_SEQ_TIMEOUT_EN
        begin
            exp_t e;
            e = '0;
            e.timeout = 1;
            e.err = 1;
            e.freq = pack_freq();
            e.vol = pack_vol();
            sb.push_back(e);
        end
        send_byte(8'h00);
        idle(TO + 5);
        send_cmd(8'h52, 8'h00, 0);
`else
        send_cmd(8'h00, 8'h12, TO + 5);
`endif
        idle(3);

        for (int i = 0; i < 150; i++) begin
            logic [7:0] b0;
            logic [7:0] b1;
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            if (b0[7:6] == 2'b10) b1 = 8'($urandom_range(0, 6));
            send_cmd(b0, b1, $urandom_range(0, 3));
            idle($urandom_range(0, 6));
        end

        idle(40);
        check("scoreboard_drained", sb.size(), 0);
        check("nothing_pending", pending, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tone_cmd_sequencer.md
Name: tone_cmd_sequencer

Overview:
- Byte-serial command front end for the multi-voice tone generator.
- Accepts 8-bit command bytes from the chip input bus, decodes 1- and 2-byte commands, and holds per-voice frequency, volume and gate registers that drive the tone datapath.
- Times note durations with a shared tick prescaler and per-voice down counters, so notes end without further host traffic.

Parameters:
- NUM_VOICES, 4, number of voices (1..4; voice field is 2 bits).
- FREQ_W, 12, frequency divider width per voice.
- VOL_W, 4, volume width per voice.
- TICK_DIV, 1000, clk cycles per duration tick (>=2).
- TIMEOUT, 255, idle clk cycles allowed between bytes of a 2-byte command (optional feature only).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- cmd_data  in  8  command byte.
- cmd_valid  in  1  cmd_data valid this cycle.
- cmd_ready  out  1  byte accepted when cmd_valid && cmd_ready at rising clk.
- voice_freq  out  NUM_VOICES*FREQ_W  packed divider values; voice v at [v*FREQ_W +: FREQ_W].
- voice_vol  out  NUM_VOICES*VOL_W  packed volumes.
- voice_gate  out  NUM_VOICES  1 = voice sounding.
- cmd_err  out  1  one-cycle pulse on a rejected or aborted command.

Behaviour:
- Reset (async, rst=1): FSM=IDLE, all voice_freq/voice_vol/voice_gate=0, duration counters=0, prescaler=0, cmd_err=0, cmd_ready=0 while rst held; cmd_ready=1 the first cycle after release.
- Byte 0 layout: [7:6] op, [5:4] voice, [3:0] p.
- op 00 SET_FREQ, 2 bytes: freq = {p, byte1}. For FREQ_W > 12 the value is zero-extended; for FREQ_W < 12 it is truncated to the low bits.
- op 01 SET_VOL, 1 byte: vol = p, resized to VOL_W by the same rule.
- op 10 NOTE_ON, 2 bytes: gate=1 and duration counter=byte1. A byte1 of 0 means sustain with no auto-off.
- op 11 NOTE_OFF, 1 byte: gate=0 and counter=0. If p[0]=1, all voices are cleared regardless of the voice field.
- FSM states:
  - IDLE: cmd_ready=1. Accepting a 1-byte op moves to EXEC; accepting a 2-byte op latches byte 0 and moves to ARG.
  - ARG: cmd_ready=1. Accepting a byte latches byte1 and moves to EXEC.
  - EXEC: cmd_ready=0 for exactly one cycle. Register update happens on the EXEC→IDLE edge.
- Latency: outputs change 2 clk edges after the final byte is accepted (accept edge, then EXEC edge). Sustained throughput: 1-byte command every 2 cycles, 2-byte command every 3 cycles.
- Voice index >= NUM_VOICES: command is fully consumed (both bytes), no register changes, cmd_err pulses during the EXEC cycle.
- Prescaler: counts 0..TICK_DIV-1 and emits a 1-cycle tick at TICK_DIV-1. It free-runs and is not reset by commands.
- Duration counter: on tick, a nonzero counter decrements. The transition 1→0 clears that voice's gate on the same edge. A counter of 0 with gate=1 is sustain and is untouched by ticks.
- NOTE_ON to a voice already gated retriggers it: the counter reloads and gate stays 1.
- Same edge, command write and tick on the same voice: the command wins and the tick has no effect on that voice. Other voices still decrement.
- SET_FREQ and SET_VOL never affect gate or counter.
- Reset mid-command: partial command is discarded, FSM goes to IDLE.

Optional Feature:
- Macro: TONE_SEQ_TIMEOUT_EN.
- Defined:
  - In ARG, a counter increments each cycle without a handshake.
  - When it reaches TIMEOUT, the FSM returns to IDLE, cmd_err pulses 1 cycle, and the partial command is dropped.
  - The counter clears on entry to ARG.
- Undefined: ARG waits indefinitely and no timeout logic is synthesized.

Decomposition:
- Shared package tone_pkg:
  - Opcode constants OP_SET_FREQ=2'b00, OP_SET_VOL=2'b01, OP_NOTE_ON=2'b10, OP_NOTE_OFF=2'b11.
  - FSM encoding IDLE/ARG/EXEC.
  - Byte-0 field positions.
- Sub-module tone_duration_timer: one voice's 8-bit counter plus gate register, with load/clear/tick inputs and the command-wins priority. Instantiated NUM_VOICES times.
- Prescaler and decode FSM stay in tone_cmd_sequencer.

Test Plan:
- Reset then release: all outputs 0, cmd_ready=1 on the first cycle after rst falls. Assert rst mid-ARG → FSM IDLE; the next byte 0x41 sets voice0 vol=1.
- Bytes 0x13,0x45 (SET_FREQ voice1): voice1 freq=0x345 two edges after the second byte; cmd_ready=0 for exactly 1 cycle; other voices unchanged.
- TICK_DIV=4, bytes 0x80,0x03 (NOTE_ON voice0, dur 3): gate=1, then cleared on the 3rd tick. Bytes 0x80,0x00: gate stays 1 for 100 ticks. Byte 0xC1: all gates 0.
- Retrigger: NOTE_ON voice2 dur 2, then after 1 tick NOTE_ON voice2 dur 5: gate stays 1 and clears 5 ticks after the reload. A tick coincident with the EXEC edge does not decrement the reloaded value.
- NUM_VOICES=2, bytes 0x30,0xAA: cmd_err 1-cycle pulse, no freq change; the following 0x41 is decoded normally.
- TONE_SEQ_TIMEOUT_EN with TIMEOUT=10: send 0x00, then idle 10 cycles: cmd_err pulse, FSM IDLE. The next byte is treated as byte 0. Without the macro, the same stimulus keeps the FSM in ARG.
